// File: rtl/v_hier_pkg.sv
// Shared defaults and the round-robin index helper for the v_hier channel array.
package v_hier_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 4;

  // Successor of cur in a ring of n channels.
  function automatic int rr_next(input int cur, input int n);
    int nxt;
    if (cur >= n - 1) begin
      nxt = 0;
    end else begin
      nxt = cur + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/v_hier_chan.sv
// One channel FIFO: DEPTH entries, natural pointer wrap, registered occupancy count.
module v_hier_chan
  import v_hier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == {(AW + 1){1'b0}});
  assign dout    = mem[rd_ptr];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{(AW - 1){1'b0}}, 1'b1};
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/v_hier_chan_array.sv
// CHANNELS buffered input channels merged round-robin onto one registered valid/ready stream.
module v_hier_chan_array
  import v_hier_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    avec,
  output logic [WIDTH-1:0]             qvec,
  output logic [CW-1:0]                q_chan,
  output logic                         q_valid,
  input  logic                         q_ready,
  output logic [CHANNELS*(AW+1)-1:0]   fill
);

  logic [CHANNELS-1:0]             push;
  logic [CHANNELS-1:0]             pop;
  logic [CHANNELS-1:0]             full;
  logic [CHANNELS-1:0]             empty;
  logic [CHANNELS-1:0][WIDTH-1:0]  douts;
  logic [CHANNELS-1:0][AW:0]       counts;
  logic [CW-1:0]                   last_grant;
  logic [CW-1:0]                   grant;
  logic [CW-1:0]                   idx;
  logic                            found;
  logic                            free;
  logic                            take;

  assign free = !q_valid || q_ready;
  assign take = free && found;
  assign fill = counts;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    // in_ready comes from the registered count only, so a full FIFO never accepts
    // even when it is being popped in the same cycle.
    assign in_ready[c] = !full[c];
    assign push[c]     = in_valid[c] && in_ready[c];
    assign pop[c]      = take && (grant == CW'(c));

    v_hier_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .din   (avec[c*WIDTH +: WIDTH]),
      .pop   (pop[c]),
      .dout  (douts[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (counts[c])
    );
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found = 1'b0;
    grant = last_grant;
    idx   = last_grant;
    for (int i = 0; i < CHANNELS; i++) begin
      idx   = CW'(rr_next(int'(idx), CHANNELS));
      grant = (!found && !empty[idx]) ? idx : grant;
      found = found || !empty[idx];
    end
  end

  // Output stage and grant pointer; both hold while the stage is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid    <= 1'b0;
      qvec       <= {WIDTH{1'b0}};
      q_chan     <= {CW{1'b0}};
      last_grant <= CW'(CHANNELS - 1);
    end else if (free) begin
      if (found) begin
        q_valid    <= 1'b1;
        qvec       <= douts[grant];
        q_chan     <= grant;
        last_grant <= grant;
      end else begin
        q_valid    <= 1'b0;
      end
    end
  end

endmodule
